// File: rtl/seq_lock_pkg.sv
// Shared types and helpers for the seq_lock combination lock.
// Provides the FSM state enum, arming length and width helpers.
package seq_lock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        UNLOCKED,
        LOCKOUT
    } state_e;

    // Cycles after reset during which press pulses are suppressed.
    localparam int ARM_CYCLES = 3;

    // Symbol width for n buttons: clog2(n), but never below 1 bit.
    function automatic int sym_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_lock_btn_sync_edge.sv
// Button front end: 2-FF synchroniser, rising-edge pulse, arming.
// Ports: clk, rst (sync, active high), btn_i raw levels, press_o pulses.
module btn_sync_edge
    import seq_lock_pkg::*;
#(
    parameter int NBTN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_i,
    output logic [NBTN-1:0] press_o
);

    logic [NBTN-1:0] s1_q;
    logic [NBTN-1:0] s2_q;
    logic [NBTN-1:0] s3_q;
    logic [1:0]      arm_q;
    logic            armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            arm_q <= '0;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
            if (!armed) begin
                arm_q <= arm_q + 2'd1;
            end
        end
    end

    // A button held through reset rises in s2 within the arming
    // window, so masking those cycles swallows that spurious edge.
    assign armed   = (arm_q == 2'(ARM_CYCLES));
    assign press_o = armed ? (s2_q & ~s3_q) : '0;

endmodule

// File: rtl/seq_lock.sv
// seq_lock: sequence-entry combination lock with timeout and unlock window.
// Ports: clk, rst (sync, active high), btn raw buttons; outputs unlocked,
// alarm, progress, fail_cnt (registered) and press (debug pulses).
// Build option: define SEQ_LOCK_LOCKOUT_EN to include the lockout state.
module seq_lock
    import seq_lock_pkg::*;
#(
    parameter int NBTN           = 2,
    parameter int CODE_LEN       = 6,
    parameter logic [sym_w(NBTN)*CODE_LEN-1:0] CODE = 6'b011101,
    parameter int UNLOCK_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NBTN-1:0]                 btn,
    output logic                            unlocked,
    output logic                            alarm,
    output logic [$clog2(CODE_LEN+1)-1:0]   progress,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
    output logic [NBTN-1:0]                 press
);

    localparam int SYM_W   = sym_w(NBTN);
    localparam int PW      = $clog2(CODE_LEN + 1);
    localparam int FW      = $clog2(MAX_FAIL + 1);
    localparam int CNT_MAX = max3(UNLOCK_CYCLES, TIMEOUT_CYCLES,
                                  LOCKOUT_CYCLES);
    localparam int CW      = sym_w(CNT_MAX);

    localparam logic [CW-1:0] UNLOCK_LD  = CW'(UNLOCK_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_CYCLES - 1);
`ifdef SEQ_LOCK_LOCKOUT_EN
    localparam logic [CW-1:0] LOCK_LD    = CW'(LOCKOUT_CYCLES - 1);
`endif

    state_e          state_q;
    logic [PW-1:0]   prog_q;
    logic [FW-1:0]   fail_q;
    logic [CW-1:0]   cnt_q;
    logic            unlocked_q;
`ifdef SEQ_LOCK_LOCKOUT_EN
    logic            alarm_q;
`endif

    logic [SYM_W-1:0] sym;
    logic [SYM_W-1:0] exp_sym;
    logic [FW-1:0]    fail_inc;
    logic             any_press;
    logic             hit;

    btn_sync_edge #(
        .NBTN (NBTN)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn),
        .press_o (press)
    );

    // Index of the pressed button; only meaningful when one-hot,
    // which also guarantees the index is below NBTN.
    always_comb begin
        sym = '0;
        for (int i = 0; i < NBTN; i++) begin
            if (press[i]) begin
                sym = SYM_W'(i);
            end
        end
    end

    always_comb begin
        exp_sym = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (prog_q == PW'(i)) begin
                exp_sym = CODE[i*SYM_W +: SYM_W];
            end
        end
    end

    assign any_press = |press;
    assign hit       = $onehot(press) && (sym == exp_sym);
    assign fail_inc  = (fail_q == FW'(MAX_FAIL)) ? fail_q
                                                 : fail_q + FW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prog_q     <= '0;
            fail_q     <= '0;
            cnt_q      <= '0;
            unlocked_q <= 1'b0;
`ifdef SEQ_LOCK_LOCKOUT_EN
            alarm_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE, ENTRY: begin
                    if (any_press) begin
                        if (hit && prog_q == PW'(CODE_LEN - 1)) begin
                            state_q    <= UNLOCKED;
                            prog_q     <= '0;
                            fail_q     <= '0;
                            cnt_q      <= UNLOCK_LD;
                            unlocked_q <= 1'b1;
                        end else if (hit) begin
                            state_q <= ENTRY;
                            prog_q  <= prog_q + PW'(1);
                            cnt_q   <= TIMEOUT_LD;
                        end else begin
                            prog_q <= '0;
                            fail_q <= fail_inc;
                            cnt_q  <= '0;
                            state_q <= IDLE;
`ifdef SEQ_LOCK_LOCKOUT_EN
                            if (fail_inc == FW'(MAX_FAIL)) begin
                                state_q <= LOCKOUT;
                                cnt_q   <= LOCK_LD;
                                alarm_q <= 1'b1;
                            end
`endif
                        end
                    end else if (state_q == ENTRY) begin
                        // Abandoned entry: drop progress, not a failure.
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                            prog_q  <= '0;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                UNLOCKED: begin
                    if (cnt_q == '0) begin
                        state_q    <= IDLE;
                        unlocked_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                LOCKOUT: begin
`ifdef SEQ_LOCK_LOCKOUT_EN
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        fail_q  <= '0;
                        alarm_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
`else
                    state_q <= IDLE;
`endif
                end
            endcase
        end
    end

    assign unlocked = unlocked_q;
    assign progress = prog_q;
    assign fail_cnt = fail_q;
`ifdef SEQ_LOCK_LOCKOUT_EN
    assign alarm    = alarm_q;
`else
    assign alarm    = 1'b0;
`endif

endmodule

// File: tb/tb_seq_lock.sv
// Self-checking bench for seq_lock at default parameters.
// Expected outputs are queued per press and popped once consumed.
module tb_seq_lock;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn = 2'b00;
    logic       unlocked;
    logic       alarm;
    logic [2:0] progress;
    logic [1:0] fail_cnt;
    logic [1:0] press;
    logic [6:0] obs;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];

    localparam logic [5:0] CODE_V = 6'b011101;

    seq_lock dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .unlocked (unlocked),
        .alarm    (alarm),
        .progress (progress),
        .fail_cnt (fail_cnt),
        .press    (press)
    );

    always #5 clk = ~clk;

    assign obs = {progress, fail_cnt, unlocked, alarm};

    function automatic logic [6:0] mk(input int p, input int f,
                                      input bit u, input bit a);
        return {3'(p), 2'(f), u, a};
    endfunction

    task automatic apply_reset();
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Rise sampled at edge k; mid is observed after k+1, return after k+2.
    task automatic do_press(input logic [1:0] m, output logic [1:0] seen,
                            output logic [6:0] mid);
        @(negedge clk) btn = m;
        @(negedge clk) btn = 2'b00;
        @(negedge clk);
        seen = press;
        mid  = obs;
        @(negedge clk);
    endtask

    task automatic run_code(input int f0, input string tag);
        logic [1:0] seen, m;
        logic [6:0] mid, e, prev;
        int n;
        prev = mk(0, f0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            m = CODE_V[i] ? 2'b10 : 2'b01;
            exp_q.push_back(i == 5 ? mk(0, 0, 1, 0) : mk(i + 1, f0, 0, 0));
            do_press(m, seen, mid);
            e = exp_q.pop_front();
            checks++;
            if (seen !== m || mid !== prev) begin
                errors++;
                $display("FAIL %s_pre%0d: press=%b st=%h want press=%b st=%h",
                         tag, i, seen, mid, m, prev);
            end
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s_sym%0d: st=%h want %h", tag, i, obs, e);
            end
            prev = e;
        end
        n = 0;
        while (unlocked === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 16 || obs !== mk(0, 0, 0, 0)) begin
            errors++;
            $display("FAIL %s_window: cycles=%0d st=%h want 16 st=%h",
                     tag, n, obs, mk(0, 0, 0, 0));
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 7'h00 || press !== 2'b00) begin
            errors++;
            $display("FAIL reset: st=%h press=%b want 00 00", obs, press);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_held_reset();
        logic [1:0] acc;
        acc = 2'b00;
        btn = 2'b01;
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            acc = acc | press;
        end
        btn = 2'b00;
        repeat (4) @(negedge clk);
        checks++;
        if (acc !== 2'b00 || obs !== 7'h00) begin
            errors++;
            $display("FAIL held_reset: press=%b st=%h want 00 00", acc, obs);
        end
    endtask

    task automatic test_unlock();
        apply_reset();
        run_code(0, "unlock");
    endtask

    task automatic test_wrong();
        logic [1:0] seen;
        logic [6:0] mid, e;
        logic [1:0] seq [3];
        seq = '{2'b10, 2'b01, 2'b01};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(i == 2 ? mk(0, 1, 0, 0) : mk(i + 1, 0, 0, 0));
            do_press(seq[i], seen, mid);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL wrong%0d: st=%h want %h", i, obs, e);
            end
        end
        run_code(1, "after_wrong");
    endtask

    task automatic test_both();
        logic [1:0] seen;
        logic [6:0] mid, e;
        logic [1:0] seq [3];
        seq = '{2'b10, 2'b01, 2'b11};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(i == 2 ? mk(0, 1, 0, 0) : mk(i + 1, 0, 0, 0));
            do_press(seq[i], seen, mid);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e || seen !== seq[i]) begin
                errors++;
                $display("FAIL both%0d: st=%h press=%b want %h %b",
                         i, obs, seen, e, seq[i]);
            end
        end
    endtask

    task automatic test_lockout();
        logic [1:0] seen;
        logic [6:0] mid, e;
        int n;
        apply_reset();
`ifdef SEQ_LOCK_LOCKOUT_EN
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                exp_q.push_back(mk(0, i + 1, 0, i == 2));
                do_press(2'b01, seen, mid);
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL lock%0d_wrong%0d: st=%h want %h",
                             r, i, obs, e);
                end
            end
            n = 0;
            if (r == 1) begin
                exp_q.push_back(mk(0, 3, 0, 1));
                do_press(2'b10, seen, mid);
                e = exp_q.pop_front();
                n = 4;
                checks++;
                if (obs !== e || seen !== 2'b10) begin
                    errors++;
                    $display("FAIL lock_ignore: st=%h press=%b want %h 10",
                             obs, seen, e);
                end
            end
            while (alarm === 1'b1 && n < 400) begin
                n++;
                @(negedge clk);
            end
            checks++;
            if (n != 256 || obs !== mk(0, 0, 0, 0)) begin
                errors++;
                $display("FAIL lock%0d_window: cycles=%0d st=%h want 256 00",
                         r, n, obs);
            end
        end
        run_code(0, "after_lock");
`else
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(0, (i < 3) ? i + 1 : 3, 0, 0));
            do_press(2'b01, seen, mid);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL sat_wrong%0d: st=%h want %h", i, obs, e);
            end
        end
        run_code(3, "after_sat");
`endif
    endtask

    task automatic test_timeout();
        logic [1:0] seen;
        logic [6:0] mid, e;
        logic [1:0] seq [3];
        seq = '{2'b01, 2'b10, 2'b01};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(i, 1, 0, 0));
            do_press(seq[i], seen, mid);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL tmo_setup%0d: st=%h want %h", i, obs, e);
            end
        end
        repeat (1020) @(negedge clk);
        checks++;
        if (obs !== mk(2, 1, 0, 0)) begin
            errors++;
            $display("FAIL tmo_early: st=%h want %h", obs, mk(2, 1, 0, 0));
        end
        repeat (10) @(negedge clk);
        checks++;
        if (obs !== mk(0, 1, 0, 0)) begin
            errors++;
            $display("FAIL tmo_expire: st=%h want %h", obs, mk(0, 1, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] e;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk) btn = CODE_V[i] ? 2'b10 : 2'b01;
            @(negedge clk) btn = 2'b00;
        end
        exp_q.push_back(mk(0, 0, 1, 0));
        @(negedge clk);
        checks++;
        if (obs !== mk(5, 0, 0, 0)) begin
            errors++;
            $display("FAIL b2b_pre: st=%h want %h", obs, mk(5, 0, 0, 0));
        end
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL b2b_unlock: st=%h want %h", obs, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] seen;
        logic [6:0] mid;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            do_press(CODE_V[i] ? 2'b10 : 2'b01, seen, mid);
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 7'h00 || press !== 2'b00) begin
            errors++;
            $display("FAIL rst_unlocked: st=%h press=%b want 00 00",
                     obs, press);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            do_press(2'b01, seen, mid);
        end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 7'h00 || press !== 2'b00) begin
            errors++;
            $display("FAIL rst_lockout: st=%h press=%b want 00 00",
                     obs, press);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        run_code(0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_held_reset();
        test_unlock();
        test_wrong();
        test_both();
        test_lockout();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1);
    end

endmodule
